// File: rtl/io_timer_device.sv
// io_timer_device: memory-mapped 64-bit cycle counter plus countdown timer with interrupt; optional macro IO_TIMER_AUTO_RELOAD_EN enables CTRL.auto_reload
module io_timer_device #(
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        timer_interrupt
);
`ifdef IO_TIMER_AUTO_RELOAD_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b101;
`endif
  logic [63:0] cycle;
  logic [31:0] cycle_hi, load, value, rd;
  logic [2:0]  ctrl, off;
  logic        expired, hit, wr_load, wr_ctrl, wr_status, expire, reload;
  logic        unused_addr_bits;
  assign unused_addr_bits = ^io_address[1:0];
  assign hit       = io_address[31:5] == BASE_ADDRESS[31:5];
  assign off       = io_address[4:2];
  assign wr_load   = io_write_en & hit & (off == 3'd2);
  assign wr_ctrl   = io_write_en & hit & (off == 3'd3);
  assign wr_status = io_write_en & hit & (off == 3'd4) & io_write_data[0];
  // a count of 1 finishes this cycle; a count of 0 with enable set finishes immediately
  assign expire    = ctrl[0] & (value <= 32'd1);
  assign reload    = ctrl[1] & (value == 32'd1);
  assign timer_interrupt = expired & ctrl[2];
  // register read mux; misses and unmapped offsets read as zero
  always_comb
    rd = !hit          ? 32'd0 :
         off == 3'd0   ? cycle[31:0] :
         off == 3'd1   ? cycle_hi :
         off == 3'd2   ? load :
         off == 3'd3   ? {29'd0, ctrl} :
         off == 3'd4   ? {31'd0, expired} :
         off == 3'd5   ? value : 32'd0;
  // counter, countdown and bus writes; later bus writes override the timer's own update
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle        <= '0;
      cycle_hi     <= '0;
      load         <= '0;
      value        <= '0;
      ctrl         <= '0;
      expired      <= 1'b0;
      io_read_data <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (io_read_en) io_read_data <= rd;
      if (io_read_en && hit && off == 3'd0) cycle_hi <= cycle[63:32];
      if (ctrl[0]) begin
        value <= value > 32'd1 ? value - 32'd1 : reload ? load : 32'd0;
        if (expire && !reload) ctrl[0] <= 1'b0;
      end
      expired <= expire | (expired & ~wr_status);
      if (wr_load) begin
        load  <= io_write_data;
        value <= io_write_data;
      end
      if (wr_ctrl) begin
        ctrl <= io_write_data[2:0] & CTRL_MASK;
        if (expire) value <= 32'd0;
      end
    end
  end
endmodule
